// File: rtl/r_fifo_wr_arb.sv
// Two-requester packet arbiter for the r_fifo write port: round-robin per packet,
// one header word tagging the source, FULL backpressure and idle-timeout abort.
module r_fifo_wr_arb #(
    parameter int DW      = 8,
    parameter int TIMEOUT = 16
) (
    input  logic          CLOCK,
    input  logic          RESET,
    input  logic          REQ0,
    input  logic          REQ1,
    input  logic          VALID0,
    input  logic          VALID1,
    input  logic          LAST0,
    input  logic          LAST1,
    input  logic [DW-1:0] DATA0,
    input  logic [DW-1:0] DATA1,
    output logic          GNT0,
    output logic          GNT1,
    output logic          READY0,
    output logic          READY1,
    output logic          ABORT,
    output logic [DW-1:0] FIFO_DATA,
    output logic          FIFO_WE,
    input  logic          FIFO_FULL
);

    typedef enum logic [1:0] {IDLE, HDR, XFER} state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t        state, state_nxt;
    logic          src, rr, sel;
    logic [7:0]    cnt;
    logic          valid_s, last_s, acc, idle_tick, tmo;
    logic [DW-1:0] hdr;

    assign valid_s   = src ? VALID1 : VALID0;
    assign last_s    = src ? LAST1 : LAST0;
    assign acc       = (state == XFER) && valid_s && !FIFO_FULL;
    assign idle_tick = (state == XFER) && !valid_s && !FIFO_FULL;
    // An accepted word is never an idle cycle, so LAST always beats the timeout.
    assign tmo       = idle_tick && (cnt == CNT_LAST);
    assign sel       = (REQ0 && REQ1) ? ~rr : REQ1;

    always_comb begin
        hdr              = '0;
        hdr[DW-1:DW-4]   = 4'hA;
        hdr[0]           = src;
    end

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            state <= IDLE;
            src   <= 1'b0;
            rr    <= 1'b1;
            cnt   <= '0;
            GNT0  <= 1'b0;
            GNT1  <= 1'b0;
            ABORT <= 1'b0;
        end else begin
            state <= state_nxt;
            ABORT <= tmo;
            case (state)
                IDLE: begin
                    if (REQ0 || REQ1) begin
                        src  <= sel;
                        GNT0 <= ~sel;
                        GNT1 <= sel;
                    end
                end
                HDR: begin
                    if (!FIFO_FULL) cnt <= '0;
                end
                XFER: begin
                    if ((acc && last_s) || tmo) begin
                        GNT0 <= 1'b0;
                        GNT1 <= 1'b0;
                        rr   <= src;
                    end else if (acc) begin
                        cnt <= '0;
                    end else if (idle_tick) begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (REQ0 || REQ1) state_nxt = HDR;
            HDR:     if (!FIFO_FULL) state_nxt = XFER;
            XFER:    if ((acc && last_s) || tmo) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        READY0    = 1'b0;
        READY1    = 1'b0;
        FIFO_WE   = 1'b0;
        FIFO_DATA = hdr;
        case (state)
            HDR: FIFO_WE = !FIFO_FULL;
            XFER: begin
                READY0    = !src && !FIFO_FULL;
                READY1    = src && !FIFO_FULL;
                FIFO_DATA = src ? DATA1 : DATA0;
                FIFO_WE   = valid_s && !FIFO_FULL;
            end
            default: ;
        endcase
    end

endmodule

// File: doc/r_fifo_wr_arb.md
# r_fifo_wr_arb

Single-clock, two-requester write arbiter in front of the r_fifo write port. Packet-level round-robin; each granted packet is preceded by a one-word header tagging its source. Honours FULL backpressure and aborts a stalled packet after a programmable idle timeout. Sits between the sample/packet sources and the FIFO write side; CLOCK drives the FIFO's WCLOCK.

## Interface
- DW, 8: data width; must be ≥ 5.
- TIMEOUT, 16: idle XFER cycles before abort; range 1..255.
- CLOCK  in  1  write-side clock; all state updates on rising edge.
- RESET  in  1  asynchronous, active-low reset.
- REQ0, REQ1  in  1  requester n has a packet pending.
- VALID0, VALID1  in  1  DATAn holds a valid word.
- LAST0, LAST1  in  1  the current word is the final word of the packet.
- DATA0, DATA1  in  DW  requester payload.
- GNT0, GNT1  out  1  requester n owns the FIFO (registered).
- READY0, READY1  out  1  the word is accepted this cycle when VALIDn is also high (combinational).
- ABORT  out  1  one-cycle pulse: the granted packet was terminated by timeout.
- FIFO_DATA  out  DW  to r_fifo DATA.
- FIFO_WE  out  1  to r_fifo WE (combinational).
- FIFO_FULL  in  1  from r_fifo FULL.

## Operation
- States: IDLE, HDR, XFER. Registers: state, src (1 bit), rr (last served, 1 bit), idle counter (8 bits).
- IDLE: no grant. If exactly one REQ is high, select it. If both are high, select the requester ≠ rr. Transition: src ← selected; GNTsrc ← 1; state ← HDR.
- HDR:
  - FIFO_DATA = {4'hA, (DW-5) zeros, src}.
  - FIFO_WE = ~FIFO_FULL.
  - When FIFO_WE is high: state ← XFER; idle counter ← 0.
- XFER:
  - READYsrc = ~FIFO_FULL; the other READY is 0.
  - FIFO_DATA = DATAsrc; FIFO_WE = VALIDsrc & READYsrc.
  - Accepted word with LASTsrc = 1: state ← IDLE; GNT ← 0; rr ← src.
  - Accepted word without LAST: idle counter ← 0.
  - Cycle with FIFO_FULL = 0 and VALIDsrc = 0: counter increments.
  - Cycles with FIFO_FULL = 1 do not increment the counter.
  - Counter reaches TIMEOUT−1 and increments again: state ← IDLE; GNT ← 0; ABORT pulses the next cycle; rr ← src.
- The ungranted requester's READY is always 0. Outside XFER, both READYs are 0.
- In IDLE and HDR, FIFO_DATA outside a write is don't-care; it is driven as the header value.
- REQ is sampled only in IDLE. Deasserting REQ mid-packet has no effect; the packet ends only by LAST or timeout.
- The arbiter never writes when FIFO_FULL = 1, in any state.

## Timing
- Reset values: state IDLE; GNT0 = GNT1 = 0; READY0 = READY1 = 0; FIFO_WE = 0; ABORT = 0; rr = 1, so requester 0 wins the first tie; counter = 0.
- Reset asserted mid-packet clears all state immediately; no partial header is written.
- Latency, REQ high in IDLE:
  - GNT rises at edge 1.
  - Header is written during cycle 1 (if not FULL).
  - The first payload word can be accepted in cycle 2.
- Minimum per-packet overhead is 2 cycles (arbitration + header). Back-to-back packets: the IDLE cycle following LAST re-arbitrates.
- A LAST word and a timeout in the same cycle: LAST wins, and ABORT stays 0.
- FIFO_FULL rising in HDR holds the header until FULL falls; no timeout runs in HDR.
- FIFO_WE and READY are combinational from FIFO_FULL. FIFO_FULL must be valid before the rising edge, as r_fifo provides in the write domain.

## Test plan
- Reset hold, then release with REQ0 = REQ1 = 0 → all outputs 0 and state IDLE for 10 cycles.
- Single packet from requester 0:
  - Stimulus: REQ0 = 1 with VALID0 and words AA, BB, CC, LAST on CC.
  - Required FIFO write sequence: A0, AA, BB, CC on consecutive cycles.
  - GNT0 falls after CC; 4 total writes.
- Tie and fairness: REQ0 = REQ1 = 1 continuously with 2-word packets (0: 11, 22; 1: 33, 44) → writes A0, 11, 22, A1, 33, 44, A0, 11, 22…; strict alternation.
- Backpressure:
  - Stimulus: FIFO_FULL = 1 for 5 cycles during XFER with VALID0 high.
  - Required: READY0 = 0 and FIFO_WE = 0 throughout; no ABORT; word written on the first cycle after FULL falls.
  - Repeat with FULL during HDR: header held.
- Timeout:
  - Stimulus: TIMEOUT = 4; grant requester 1; send one word, then VALID1 = 0.
  - Required: ABORT is a single-cycle pulse after 4 idle cycles; GNT1 drops; a pending REQ0 is granted in the following IDLE.
- Async reset mid-XFER: assert RESET between edges → GNT, FIFO_WE and READY drop immediately; after release the next tie goes to requester 0.
